// File: rtl/keycode_slot_tracker_if.sv
// Event/publish bundle between the keyboard front end, keycode_slot_tracker
// and the movement blocks that consume the published keycode word.
interface keycode_slot_tracker_if;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_make;
    logic [7:0]  ev_code;
    logic        frame_tick;
    logic        clear;
    logic [31:0] keycode;
    logic        overflow;
    logic [2:0]  key_count;

    modport master (
        output ev_valid, ev_make, ev_code, frame_tick, clear,
        input  ev_ready, keycode, overflow, key_count
    );

    modport slave (
        input  ev_valid, ev_make, ev_code, frame_tick, clear,
        output ev_ready, keycode, overflow, key_count
    );
endinterface

// File: rtl/keycode_slot_tracker.sv
// Keeps an ordered 4-slot set of held HID keys from make/break events and
// publishes it once per frame_tick, or the rollover pattern on overflow.
module keycode_slot_tracker #(
    parameter logic [7:0] ROLLOVER_CODE = 8'h01
) (
    input  logic                  Clk,
    input  logic                  Reset,
    keycode_slot_tracker_if.slave bus
);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t      state_q, state_d;
    logic        ev_make_q, ev_make_d;
    logic [7:0]  ev_code_q, ev_code_d;
    logic [7:0]  slot_q [4];
    logic [7:0]  slot_d [4];
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  ovf_q, ovf_d;
    logic [31:0] keycode_q, keycode_d;
    logic        overflow_q, overflow_d;

    logic        accept;
    logic [3:0]  hit;
    logic [1:0]  hit_idx;
    logic        found;

    assign bus.ev_ready  = (state_q == IDLE) && !Reset && !bus.clear;
    assign accept        = bus.ev_valid && bus.ev_ready;
    assign bus.keycode   = keycode_q;
    assign bus.overflow  = overflow_q;
    assign bus.key_count = cnt_q;

    // Occupied slots never repeat a code, so at most one hit bit is set.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((3'(i) < cnt_q) && (slot_q[i] == ev_code_q)) hit[i] = 1'b1;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (hit[i]) hit_idx = 2'(i);
        end
        found = |hit;
    end

    always_comb begin
        state_d    = state_q;
        ev_make_d  = ev_make_q;
        ev_code_d  = ev_code_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        keycode_d  = keycode_q;
        overflow_d = overflow_q;

        // Snapshot uses the registered state, i.e. before any same-cycle update or clear.
        if (bus.frame_tick) begin
            overflow_d = (ovf_q != '0);
            keycode_d  = (ovf_q != '0) ? {4{ROLLOVER_CODE}}
                                       : {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
        end

        if (bus.clear) begin
            state_d = IDLE;
            slot_d  = '{default: '0};
            cnt_d   = '0;
            ovf_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ev_make_d = bus.ev_make;
                        ev_code_d = bus.ev_code;
                        state_d   = UPDATE;
                    end
                end
                UPDATE: begin
                    state_d = IDLE;
                    if (ev_make_q) begin
                        if ((ev_code_q != '0) && !found) begin
                            if (cnt_q < 3'd4) begin
                                slot_d[cnt_q[1:0]] = ev_code_q;
                                cnt_d              = cnt_q + 3'd1;
                            end else if (ovf_q != 4'hF) begin
                                ovf_d = ovf_q + 4'd1;
                            end
                        end
                    end else if (found) begin
                        // Close the gap; slots at or above cnt are already zero.
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (2'(i) >= hit_idx) slot_d[i] = slot_q[i + 1];
                        end
                        slot_d[3] = '0;
                        cnt_d     = cnt_q - 3'd1;
                    end else if (ovf_q != '0) begin
                        ovf_d = ovf_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            ev_make_q  <= 1'b0;
            ev_code_q  <= '0;
            slot_q     <= '{default: '0};
            cnt_q      <= '0;
            ovf_q      <= '0;
            keycode_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ev_make_q  <= ev_make_d;
            ev_code_q  <= ev_code_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            keycode_q  <= keycode_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
